led_wave_ctrl: RTL and testbench

Input-conditioning and timing stage that sits directly upstream of the LED wave display block. It synchronizes and debounces the raw active-low Left/Right push-buttons and the Sw speed switch, and holds the current wave direction in a small FSM. It generates a one-cycle step pulse at the selected rate (slow 4 Hz / fast 8 Hz at 50 MHz). The downstream display advances or retreats its LED position by one on each step, per dir.

---
 rtl/led_wave_ctrl.sv | 130 +++++++++++++
 tb/tb_led_wave_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_wave_ctrl.sv
// Button/switch conditioning, wave direction FSM and step-rate divider.
// This stage feeds the LED wave display, which moves one position per step according to dir.
module led_wave_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int SLOW_DIV  = 12500000,
  parameter int FAST_DIV  = 6250000,
  parameter int CNT_W     = 24
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Left,
  input  logic       Right,
  input  logic       Sw,
  output logic [1:0] dir,
  output logic       step,
  output logic       fast,
  output logic       left_evt,
  output logic       right_evt
);

  localparam int DB_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 2);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  // Channel order {Sw, Right, Left}; buttons idle high, the switch idles low.
  localparam logic [2:0] IDLE_LVL = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LEFT  = 2'b10,
    RIGHT = 2'b01
  } dir_e;

  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q, prev_q;
  logic [2:0]      db_q, db_d;
  logic [1:0]      db_prev_q;
  logic [DB_W-1:0] dbc_q [3];
  logic [DB_W-1:0] dbc_d [3];
  logic [1:0]      evt;
  logic            fast_chg;

  dir_e             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_last;
  logic             step_q, step_d;

  assign raw = {Sw, Right, Left};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sync1_q   <= IDLE_LVL;
      sync2_q   <= IDLE_LVL;
      prev_q    <= IDLE_LVL;
      db_q      <= IDLE_LVL;
      db_prev_q <= IDLE_LVL[1:0];
      for (int i = 0; i < 3; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      db_q      <= db_d;
      db_prev_q <= db_q[1:0];
      for (int i = 0; i < 3; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  // The clearing edge counts as the first stable sample, so the level is
  // accepted on the DB_CYCLES-th consecutive sample that differs from db_q.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] == db_q[i] || sync2_q[i] != prev_q[i]) begin
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DB_LAST) begin
        db_d[i] = sync2_q[i];
      end else begin
        dbc_d[i] = dbc_q[i] + 1'b1;
      end
    end
  end

  assign evt      = db_prev_q & ~db_q[1:0];
  assign fast_chg = db_d[2] != db_q[2];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (evt[0] && !evt[1]) begin
      state_d = LEFT;
    end else if (evt[1] && !evt[0]) begin
      state_d = RIGHT;
    end
  end

  // The divider runs on state_q, so the first step lands a full period after dir changes.
  always_comb begin
    div_last = db_q[2] ? FAST_LAST : SLOW_LAST;
    cnt_d    = '0;
    step_d   = 1'b0;
    if (state_q == IDLE || fast_chg) begin
      cnt_d  = '0;
      step_d = 1'b0;
    end else if (cnt_q == div_last) begin
      cnt_d  = '0;
      step_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  assign dir       = state_q;
  assign step      = step_q;
  assign fast      = db_q[2];
  assign left_evt  = evt[0];
  assign right_evt = evt[1];

endmodule

// File: tb/tb_led_wave_ctrl.sv
// Directed bench for led_wave_ctrl with short debounce and divider periods.
module tb_led_wave_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       Left, Right, Sw;
  logic [1:0] dir;
  logic       step, fast, left_evt, right_evt;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs; step expectation comes from a period counter.
  logic [1:0] exp_dir  = 2'b00;
  logic       exp_fast = 1'b0;
  logic       exp_levt = 1'b0;
  logic       exp_revt = 1'b0;
  logic       exp_step = 1'b0;
  logic       active   = 1'b0;
  int         since    = 0;
  int         period   = 20;

  led_wave_ctrl #(
    .DB_CYCLES(4),
    .SLOW_DIV (20),
    .FAST_DIV (10),
    .CNT_W    (8)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .Left     (Left),
    .Right    (Right),
    .Sw       (Sw),
    .dir      (dir),
    .step     (step),
    .fast     (fast),
    .left_evt (left_evt),
    .right_evt(right_evt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge Clk);
      #1;
      exp_step = 1'b0;
      if (active) begin
        since++;
        if (since == period) begin
          exp_step = 1'b1;
          since    = 0;
        end
      end
      chk("dir", 32'(dir), 32'(exp_dir));
      chk("step", 32'(step), 32'(exp_step));
      chk("fast", 32'(fast), 32'(exp_fast));
      chk("left_evt", 32'(left_evt), 32'(exp_levt));
      chk("right_evt", 32'(right_evt), 32'(exp_revt));
    end
  endtask

  initial begin
    // reset
    Rst_n = 1'b0;
    Left  = 1'b1;
    Right = 1'b1;
    Sw    = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_fast", 32'(fast), 32'd0);
    chk("rst_levt", 32'(left_evt), 32'd0);
    chk("rst_revt", 32'(right_evt), 32'd0);
    Rst_n = 1'b1;
    cyc(50);

    // 3-cycle glitch on Left is rejected
    Left = 1'b0;
    cyc(3);
    Left = 1'b1;
    cyc(12);

    // Left press: evt on cycle 6, dir on cycle 7 after the raw edge
    Left = 1'b0;
    cyc(5);
    exp_levt = 1'b1;
    cyc(1);
    exp_levt = 1'b0;
    exp_dir  = 2'b10;
    cyc(1);
    active = 1'b1;
    since  = 0;
    Left   = 1'b1;
    cyc(45);

    // Right press reverses direction without disturbing the step cadence
    Right = 1'b0;
    cyc(5);
    exp_revt = 1'b1;
    cyc(1);
    exp_revt = 1'b0;
    exp_dir  = 2'b01;
    cyc(1);
    Right = 1'b1;
    cyc(30);

    // Both buttons together: both evts, direction held
    Left  = 1'b0;
    Right = 1'b0;
    cyc(5);
    exp_levt = 1'b1;
    exp_revt = 1'b1;
    cyc(1);
    exp_levt = 1'b0;
    exp_revt = 1'b0;
    cyc(1);
    Left  = 1'b1;
    Right = 1'b1;
    cyc(20);

    // Sw to fast: divider restarts from 0 on the edge fast changes
    Sw = 1'b1;
    cyc(5);
    exp_fast = 1'b1;
    period   = 10;
    since    = -1;
    cyc(1);
    cyc(25);

    // asynchronous reset mid-period
    Rst_n = 1'b0;
    #2;
    chk("arst_dir", 32'(dir), 32'd0);
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_fast", 32'(fast), 32'd0);
    chk("arst_levt", 32'(left_evt), 32'd0);
    chk("arst_revt", 32'(right_evt), 32'd0);
    Sw       = 1'b0;
    exp_dir  = 2'b00;
    exp_fast = 1'b0;
    active   = 1'b0;
    since    = 0;
    period   = 20;
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
